register_bank: RTL and testbench



---
 rtl/regbank_pkg.sv | 13 +
 rtl/regbank_clear_fsm.sv | 70 +++++++
 rtl/register_bank.sv | 72 +++++++
 tb/tb_register_bank.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared constants and state encoding for the register bank and its clear sequencer.
package regbank_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_NUM_RD = 3;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

endpackage

// File: rtl/regbank_clear_fsm.sv
// Clear sequencer: walks cnt from 1 to NREGS-1 zeroing one register per edge, then idles in READY.
module regbank_clear_fsm
    import regbank_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_req,
    output logic              busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] CNT_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CNT_LAST  = {ADDR_W{1'b1}};

    state_e            state_r;
    state_e            state_nxt_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_nxt_s;
    logic              busy_r;

    // State, counter and registered Busy flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= CLEAR;
            cnt_r   <= CNT_FIRST;
            busy_r  <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (state_nxt_s == CLEAR);
        end
    end

    // Next-state logic; the clear strobe is held off while reset is high.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        clr_en      = 1'b0;
        case (state_r)
            CLEAR: begin
                clr_en = ~reset;
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = READY;
                    cnt_nxt_s   = CNT_FIRST;
                end else begin
                    cnt_nxt_s = cnt_r + ADDR_W'(1);
                end
            end
            READY: begin
                if (clear_req) begin
                    state_nxt_s = CLEAR;
                    cnt_nxt_s   = CNT_FIRST;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = CLEAR;
                cnt_nxt_s   = CNT_FIRST;
            end
        endcase
    end

    assign busy     = busy_r;
    assign clr_addr = cnt_r;

endmodule

// File: rtl/register_bank.sv
// Multi-read, single-write register file with hard-wired zero register,
// optional write-to-read forwarding and a sequenced clear.
module register_bank
    import regbank_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int BYPASS = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] Read,
    output logic [NUM_RD*DATA_W-1:0] Data,
    input  logic [ADDR_W-1:0]        EscReg,
    input  logic [DATA_W-1:0]        WriteData,
    input  logic                     RegWrite,
    input  logic                     ClearReq,
    output logic                     Busy
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]        rf_r [NREGS];
    logic                     clr_en_s;
    logic [ADDR_W-1:0]        clr_addr_s;
    logic                     wr_en_s;
    logic [ADDR_W-1:0]        rd_addr_s;
    logic [NUM_RD*DATA_W-1:0] rd_data_s;

    regbank_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clock     (clock),
        .reset     (reset),
        .clear_req (ClearReq),
        .busy      (Busy),
        .clr_en    (clr_en_s),
        .clr_addr  (clr_addr_s)
    );

    // A clear request in the same cycle wins over a user write.
    assign wr_en_s = RegWrite & ~Busy & ~ClearReq & ~reset & (EscReg != '0);

    // Storage update: register 0 is never written, so no bulk reset is needed.
    always_ff @(posedge clock) begin
        if (clr_en_s) begin
            rf_r[clr_addr_s] <= '0;
        end else if (wr_en_s) begin
            rf_r[EscReg] <= WriteData;
        end
    end

    // Read muxes with zero register, busy blanking and optional forwarding.
    always_comb begin
        rd_data_s = '0;
        rd_addr_s = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_addr_s = Read[i*ADDR_W +: ADDR_W];
            if (Busy || (rd_addr_s == '0)) begin
                rd_data_s[i*DATA_W +: DATA_W] = '0;
            end else if ((BYPASS != 0) && wr_en_s && (EscReg == rd_addr_s)) begin
                rd_data_s[i*DATA_W +: DATA_W] = WriteData;
            end else begin
                rd_data_s[i*DATA_W +: DATA_W] = rf_r[rd_addr_s];
            end
        end
    end

    assign Data = rd_data_s;

endmodule

// File: tb/tb_register_bank.sv
// Directed bench: default, no-forwarding and wide configurations driven side by side.
module tb_register_bank;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [8:0]  rd    = '0;
    logic [2:0]  esc   = '0;
    logic [7:0]  wdata = '0;
    logic        regwrite = 1'b0;
    logic        clearreq = 1'b0;
    logic [23:0] data_b;
    logic [23:0] data_nb;
    logic        busy_b;
    logic        busy_nb;

    logic [15:0] w_rd    = '0;
    logic [3:0]  w_esc   = '0;
    logic [15:0] w_wdata = '0;
    logic        w_regwrite = 1'b0;
    logic        w_clearreq = 1'b0;
    logic [63:0] w_data;
    logic        w_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    register_bank dut_b (
        .clock(clock), .reset(reset), .Read(rd), .Data(data_b), .EscReg(esc),
        .WriteData(wdata), .RegWrite(regwrite), .ClearReq(clearreq), .Busy(busy_b)
    );

    register_bank #(.BYPASS(0)) dut_nb (
        .clock(clock), .reset(reset), .Read(rd), .Data(data_nb), .EscReg(esc),
        .WriteData(wdata), .RegWrite(regwrite), .ClearReq(clearreq), .Busy(busy_nb)
    );

    register_bank #(.DATA_W(16), .ADDR_W(4), .NUM_RD(4)) dut_w (
        .clock(clock), .reset(reset), .Read(w_rd), .Data(w_data), .EscReg(w_esc),
        .WriteData(w_wdata), .RegWrite(w_regwrite), .ClearReq(w_clearreq), .Busy(w_busy)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rd(input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2);
        rd = {a2, a1, a0};
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        esc = a; wdata = d; regwrite = 1'b1;
        tick();
        regwrite = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < 8; a++) begin
            set_rd(3'(a), 3'(a), 3'(a));
            #1;
            for (int p = 0; p < 3; p++) begin
                chk_eq({tag, "_b"}, 32'(data_b[p*8 +: 8]), 32'h00);
                chk_eq({tag, "_nb"}, 32'(data_nb[p*8 +: 8]), 32'h00);
            end
        end
    endtask

    initial begin
        set_rd(3'd7, 3'd7, 3'd7);
        repeat (3) tick();
        chk_eq("rst_busy", 32'(busy_b), 32'h1);
        chk_eq("rst_data", 32'(data_b), 32'h0);
        chk_eq("rst_busy_w", 32'(w_busy), 32'h1);
        reset = 1'b0;

        // Default bank busy for 7 edges, wide bank for 15.
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk_eq("clr_busy", 32'(busy_b), (k < 7) ? 32'h1 : 32'h0);
            chk_eq("clr_busy_w", 32'(w_busy), (k < 15) ? 32'h1 : 32'h0);
        end
        check_all_zero("init_zero");

        // Plain write then read; write to reg 0 discarded.
        write_reg(3'd3, 8'hA5);
        set_rd(3'd3, 3'd0, 3'd0);
        #1;
        chk_eq("wr_rd3", 32'(data_b[7:0]), 32'hA5);
        chk_eq("wr_rd3_nb", 32'(data_nb[7:0]), 32'hA5);
        write_reg(3'd0, 8'hFF);
        set_rd(3'd0, 3'd0, 3'd0);
        #1;
        chk_eq("wr_reg0", 32'(data_b), 32'h0);

        // Same-cycle forwarding vs. no forwarding.
        set_rd(3'd0, 3'd5, 3'd0);
        esc = 3'd5; wdata = 8'h3C; regwrite = 1'b1;
        #1;
        chk_eq("byp_on", 32'(data_b[15:8]), 32'h3C);
        chk_eq("byp_off_old", 32'(data_nb[15:8]), 32'h00);
        tick();
        regwrite = 1'b0;
        #1;
        chk_eq("byp_off_new", 32'(data_nb[15:8]), 32'h3C);
        chk_eq("byp_on_after", 32'(data_b[15:8]), 32'h3C);

        // Load 0x11..0x77, then clear with a colliding write.
        for (int i = 1; i < 8; i++) write_reg(3'(i), 8'(i * 17));
        set_rd(3'd2, 3'd7, 3'd1);
        #1;
        chk_eq("load_r2", 32'(data_b[7:0]), 32'h22);
        chk_eq("load_r7", 32'(data_b[15:8]), 32'h77);
        chk_eq("load_r1", 32'(data_b[23:16]), 32'h11);
        clearreq = 1'b1; regwrite = 1'b1; esc = 3'd2; wdata = 8'h99;
        #1;
        chk_eq("clr_no_byp", 32'(data_b[7:0]), 32'h22);
        tick();
        clearreq = 1'b0; regwrite = 1'b0;
        chk_eq("clr_start_busy", 32'(busy_b), 32'h1);
        chk_eq("clr_blank", 32'(data_b), 32'h0);
        for (int k = 1; k <= 7; k++) begin
            if (k == 5) begin
                clearreq = 1'b1; regwrite = 1'b1; esc = 3'd2; wdata = 8'h55;
            end
            tick();
            clearreq = 1'b0; regwrite = 1'b0;
            chk_eq("clr2_busy", 32'(busy_b), (k < 7) ? 32'h1 : 32'h0);
        end
        check_all_zero("clr2_zero");

        // Reset on the 4th clear edge restarts the sequence.
        write_reg(3'd4, 8'h44);
        write_reg(3'd7, 8'h77);
        clearreq = 1'b1;
        tick();
        clearreq = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_eq("rst_mid_busy", 32'(busy_b), 32'h1);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk_eq("rst_mid_seq", 32'(busy_b), (k < 7) ? 32'h1 : 32'h0);
        end
        check_all_zero("rst_mid_zero");

        // Wide configuration: write reg 15, read on all four ports.
        for (int k = 0; k < 8; k++) tick();
        chk_eq("w_ready", 32'(w_busy), 32'h0);
        w_esc = 4'd15; w_wdata = 16'hBEEF; w_regwrite = 1'b1;
        tick();
        w_regwrite = 1'b0;
        w_rd = {4'd15, 4'd15, 4'd15, 4'd15};
        #1;
        for (int p = 0; p < 4; p++) chk_eq("w_rd15", 32'(w_data[p*16 +: 16]), 32'hBEEF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
